// File: rtl/cim_act_serializer.sv
// cim_act_serializer: bit-serial activation driver, shift aligner and per-op dot-product extractor for a CIM column
module cim_act_serializer #(
  parameter int NROWS        = 64,
  parameter int WORDLEN      = 8,
  parameter int LOG2_WORDLEN = 3,
  parameter int LOG2_NROWS   = 6,
  parameter int SUM_WIDTH    = WORDLEN + LOG2_NROWS + LOG2_WORDLEN,
  parameter int COL_LAT      = 3,
  parameter int SHIFT_LAT    = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NROWS-1:0][WORDLEN-1:0]     in_act,
  output logic [NROWS-1:0]                  ia,
  output logic [WORDLEN-1:0]                shift,
  input  logic [SUM_WIDTH-1:0]              col_sum,
  output logic [SUM_WIDTH-1:0]              result,
  output logic                              result_valid,
  output logic                              busy
);
  typedef enum logic {IDLE, SERIAL} state_t;
  state_t state, state_n;
  logic [NROWS-1:0][WORDLEN-1:0] act_q, act_n;
  logic [LOG2_WORDLEN-1:0] k, k_n;
  logic [NROWS-1:0] ia_n;
  logic last_bit, take, shv;
  logic [SHIFT_LAT-2:0] sv;
  logic [SHIFT_LAT-2:0][LOG2_WORDLEN-1:0] sk;
  logic [COL_LAT-1:0] ld;
  logic [SUM_WIDTH-1:0] snap;
  always_comb begin
    last_bit = state == SERIAL && k == LOG2_WORDLEN'(WORDLEN - 1);
    in_ready = state == IDLE || last_bit;
    take     = in_valid && in_ready;
    state_n  = take ? SERIAL : (last_bit ? IDLE : state);
    act_n    = take ? in_act : act_q;
    k_n      = take ? '0 : (state == SERIAL ? k + 1'b1 : k);
    ia_n     = '0;
    for (int r = 0; r < NROWS; r++) ia_n[r] = (state_n == SERIAL) & act_n[r][k_n];
  end
  assign busy = state == SERIAL || |sv || shv || |ld;
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      act_q        <= '0;
      k            <= '0;
      ia           <= '0;
      sv           <= '0;
      sk           <= '0;
      shv          <= 1'b0;
      shift        <= '0;
      ld           <= '0;
      snap         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state <= state_n;
      act_q <= act_n;
      k     <= k_n;
      ia    <= ia_n;
      sv[0] <= state == SERIAL;
      sk[0] <= k;
      for (int i = 1; i < SHIFT_LAT - 1; i++) begin
        sv[i] <= sv[i-1];
        sk[i] <= sk[i-1];
      end
      shv   <= sv[SHIFT_LAT-2];
      shift <= sv[SHIFT_LAT-2] ? WORDLEN'(sk[SHIFT_LAT-2]) : '0;
      ld[0] <= last_bit;
      for (int i = 1; i < COL_LAT; i++) ld[i] <= ld[i-1];
      // the column accumulator never clears, so each result is the delta between op boundaries
      result_valid <= ld[COL_LAT-1];
      if (ld[COL_LAT-1]) begin
        result <= col_sum - snap;
        snap   <= col_sum;
      end
    end
  end
endmodule

// File: tb/tb_cim_act_serializer.sv
// tb_cim_act_serializer: directed vectors against a behavioural CIM column model
module tb_cim_act_serializer;
  localparam int NR = 64;
  localparam int WL = 8;
  localparam int S  = 17;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [NR-1:0][WL-1:0] in_act = '0;
  logic [NR-1:0] ia;
  logic [WL-1:0] shift;
  logic [S-1:0] col_sum, result;
  logic result_valid, busy;
  int n_chk = 0, n_fail = 0;
  int w[NR];
  logic [S-1:0] acc;
  int st1, st2;
  logic [NR-1:0] ia_log[0:31];
  int shift_log[0:31];
  bit busy_log[0:31];
  typedef struct {
    logic [7:0] act;
    int wt;
    bit all;
    logic [S-1:0] exp;
    int gap;
    int det;
    string nm;
  } vec_t;
  vec_t tv[7];

  cim_act_serializer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .ia(ia), .shift(shift), .col_sum(col_sum),
    .result(result), .result_valid(result_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic int dot(input logic [NR-1:0] v);
    int s = 0;
    for (int r = 0; r < NR; r++) if (v[r]) s += w[r];
    return s;
  endfunction

  // column: ia -> stage -> pipeline reg (consumes shift) -> accumulator
  always @(posedge clock) begin
    if (reset) begin
      st1 <= 0;
      st2 <= 0;
      acc <= '0;
    end else begin
      st1 <= dot(ia);
      st2 <= st1;
      acc <= acc + S'(st2 <<< shift);
    end
  end
  assign col_sum = acc;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_vec(input logic [7:0] a, input int wt, input bit all);
    for (int r = 0; r < NR; r++) begin
      in_act[r] = (all || r == 0) ? a : 8'd0;
      w[r]      = (all || r == 0) ? wt : 0;
    end
  endtask

  task automatic run_op(input logic [S-1:0] exp, input string nm, input int det);
    int got = 0, cnt = 0;
    in_valid = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clock); #1;
      in_valid = 1'b0;
      ia_log[n] = ia;
      shift_log[n] = int'(shift);
      busy_log[n] = busy;
      if (result_valid) begin
        cnt++;
        if (got == 0) begin
          got = n;
          chk({nm, " result"}, 64'(result), 64'(exp));
        end
      end
    end
    chk({nm, " latency"}, 64'(got), 64'd12);
    chk({nm, " pulse count"}, 64'(cnt), 64'd1);
    if (det == 1) begin
      chk({nm, " ia T+1"}, ia_log[1], {NR{1'b1}});
      chk({nm, " ia T+2"}, ia_log[2], '0);
      chk({nm, " shift T+3"}, 64'(shift_log[3]), 64'd0);
      chk({nm, " busy T+11"}, 64'(busy_log[11]), 64'd1);
      chk({nm, " busy T+12"}, 64'(busy_log[12]), 64'd0);
    end
    if (det == 2)
      for (int k = 0; k < WL; k++)
        chk($sformatf("%s shift T+%0d", nm, 3 + k), 64'(shift_log[3 + k]), 64'(k));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int rcnt, rv_seen;
    tv[0] = '{8'd1,   1,  1'b1, S'(64),     0,  1, "ones"};
    tv[1] = '{8'hFF, -3,  1'b0, S'(-765),   0,  2, "ff_neg3"};
    tv[2] = '{8'd3,   7,  1'b0, S'(21),     0,  0, "gap_a"};
    tv[3] = '{8'd4,   7,  1'b0, S'(28),     17, 0, "gap_b"};
    tv[4] = '{8'h80,  1,  1'b1, S'(8192),   3,  0, "msb_all"};
    tv[5] = '{8'hAA, -1,  1'b1, S'(-10880), 0,  0, "aa_neg"};
    tv[6] = '{8'hFF,  4,  1'b1, S'(65280),  1,  0, "ff_all4"};
    set_vec(8'd0, 0, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    chk("reset ia", ia, '0);
    chk("reset shift", 64'(shift), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset result_valid", 64'(result_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 7; i++) begin
      repeat (tv[i].gap) begin @(posedge clock); #1; end
      set_vec(tv[i].act, tv[i].wt, tv[i].all);
      run_op(tv[i].exp, tv[i].nm, tv[i].det);
    end
    // back-to-back: reload on the last-bit cycle with no bubble
    set_vec(8'd5, 2, 1'b0);
    in_valid = 1'b1;
    rcnt = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clock); #1;
      chk($sformatf("b2b in_ready n=%0d", n), 64'(in_ready), 64'(n % 8 == 0 || n >= 24));
      if (result_valid) begin
        rcnt++;
        chk($sformatf("b2b pulse slot n=%0d", n), 64'(n == 12 || n == 20 || n == 28), 64'd1);
        chk($sformatf("b2b result n=%0d", n), 64'(result), n == 12 ? 64'd10 : (n == 20 ? 64'd400 : 64'd0));
      end
      if (n == 1) in_act[0] = 8'd200;
      if (n == 9) in_act[0] = 8'd0;
      if (n == 17) in_valid = 1'b0;
    end
    chk("b2b result count", 64'(rcnt), 64'd3);
    // reset while bit 4 is on ia
    set_vec(8'hFF, 1, 1'b1);
    in_valid = 1'b1;
    rv_seen = 0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clock); #1;
      in_valid = 1'b0;
      if (result_valid) rv_seen++;
      if (n == 6) begin
        chk("abort ia", ia, '0);
        chk("abort shift", 64'(shift), 64'd0);
        chk("abort result", 64'(result), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
      end
      if (n == 5) reset = 1'b1;
    end
    chk("abort no result_valid", 64'(rv_seen), 64'd0);
    set_vec(8'd1, 9, 1'b0);
    run_op(S'(9), "after_abort", 0);
    // drive the accumulator up to 2^16-1, then past the signed limit
    set_vec(8'd255, 257, 1'b0);
    in_act[1] = 8'd9;
    w[1] = -1;
    run_op(S'(65526), "near_max", 0);
    set_vec(8'd1, 1, 1'b1);
    run_op(S'(64), "wrap", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cim_act_serializer.md
Name: cim_act_serializer

Overview:
- Upstream and downstream companion to the CIM column; one instance sits beside each column group.
- Accepts one parallel vector of NROWS unsigned multi-bit input activations. Drives them bit-serially, LSB first, onto the column's `ia` bus. Generates the column's `shift` index, aligned to the column's internal pipeline.
- The column accumulator never clears. This block therefore snapshots the column's running `sum` at each operation boundary and reports the per-operation dot product as the difference between successive snapshots.

Parameters:
- NROWS, 64, rows per column; width of the `ia` bus.
- WORDLEN, 8, activation bit-width; equals the number of serial cycles per operation.
- LOG2_WORDLEN, 3, log2(WORDLEN).
- LOG2_NROWS, 6, log2(NROWS).
- SUM_WIDTH, WORDLEN+LOG2_NROWS+LOG2_WORDLEN, width of the column `sum` and of `result`.
- COL_LAT, 3, cycles from `ia` driven to the column `sum` reflecting that bit.
- SHIFT_LAT, 2, cycles from `ia` driven to the column consuming `shift` for that bit.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  activation vector offered.
- in_ready  out  1  vector accepted this cycle when `in_valid` and `in_ready` are both high.
- in_act  in  NROWS x WORDLEN  unsigned activations; row r is in_act[r].
- ia  out  NROWS  bit-serial activation to the column; registered.
- shift  out  WORDLEN  bit index for the column accumulator; registered.
- col_sum  in  SUM_WIDTH  column accumulated sum.
- result  out  SUM_WIDTH  signed dot product for one operation.
- result_valid  out  1  single-cycle pulse qualifying `result`.
- busy  out  1  high while any operation is serialising or still in flight.

Behaviour:
- Reset, synchronous and active-high: `ia`=0, `shift`=0, `result`=0, `result_valid`=0, `busy`=0, `in_ready`=1. Snapshot register=0, bit counter=0, delay lines cleared.
- Reset mid-operation aborts the operation: no `result_valid` for it, and the snapshot is forced to 0. The column must be reset in the same cycle; integration guarantees this.
- FSM states are IDLE and SERIAL.
  - IDLE: `ia`=0, `in_ready`=1. On handshake, latch `in_act`, set counter k=0, go to SERIAL.
  - SERIAL: during serial cycle k, `ia`[r]=in_act[r][k], driven from a registered output.
  - Accept at cycle T gives `ia` bit 0 in T+1 and bit WORDLEN-1 in T+WORDLEN.
  - `in_ready`=1 only in the cycle carrying bit WORDLEN-1. A handshake there reloads and restarts at k=0 with no bubble; otherwise return to IDLE.
- Shift alignment:
  - `shift` is a SHIFT_LAT-deep delay of {valid, k}.
  - `shift`=k in the cycle when bit k sits in the column's pipeline register.
  - `shift`=0 in slots with no valid bit; `ia` is 0 there, so the contribution is 0.
- Completion:
  - A "last" flag travels a COL_LAT-deep delay line.
  - In cycle T+WORDLEN+COL_LAT, `col_sum` is final. On that clock edge: `result` <= col_sum - snapshot, and snapshot <= col_sum.
  - `result_valid`=1 in cycle T+WORDLEN+COL_LAT+1 for exactly one cycle. Latency from accept to result is WORDLEN+COL_LAT+1 (12 with defaults).
- Arithmetic: two's-complement subtraction, modulo 2^SUM_WIDTH. Wrap of the column accumulator is transparent while a single operation's magnitude fits in SUM_WIDTH.
- Back-to-back operations: the next operation's bit 0 reaches `col_sum` one cycle after the previous operation's final cycle, so snapshots never overlap. Throughput is one operation per WORDLEN cycles.
- Idle gaps: `col_sum` stays constant because `ia`=0, so the snapshot remains valid.
- There is no result backpressure; downstream must accept every pulse.
- `busy` = (state==SERIAL) OR any valid bit in the shift or last delay lines.

Test Plan:
- Reset, then a single vector with all rows=1 and all weights=+1 in the column model (NROWS=64) → `ia`=all-ones in T+1 only, `shift`=0 in T+3, `result`=64 with `result_valid` in T+12, `busy` low in T+12.
- Row 0 act=8'hFF, weight=-3, others 0 → `shift` sequence 0..7 in T+3..T+10, `result`=-765.
- Three vectors back-to-back (acts 5, 200, 0 on row 0; weight 2) → `in_ready` only in the last-bit cycles, no bubbles. Results 10, 400, 0 at T+12, T+20, T+28.
- Idle gap of 17 cycles between two ops (act 3 then 4, weight 7) → results 21 then 28; the snapshot is unaffected by the gap.
- Reset asserted at serial cycle k=4 → no `result_valid`, all outputs at reset values next cycle. A following op (act 1, weight 9) gives `result`=9.
- Column model preloaded with accumulator near +2^(SUM_WIDTH-1)-10, op adding +64 → `result`=64 despite the accumulator wrapping.
